// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Round-robin traffic-light sequencer for NUM_DIR approaches. Each approach
// gets GREEN -> YELLOW -> ALL-RED in turn, with phase durations counted in
// tick_en pulses. Supports blanking (enable=0) and emergency preemption.
//
// Optional build macro: PED_WALK_EN adds a pedestrian WALK phase
// (ports ped_req/walk, parameter WALK_TICKS).
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   tick_en      timebase enable; phase counter advances only when high
//   enable       1 = run, 0 = blank all heads (OFF)
//   preempt_req  emergency preemption request (level)
//   preempt_dir  approach requested for preemption
//   light        2 bits per approach: 00 red, 01 yellow, 10 green, 11 off
//   active_dir   approach green/yellow, or next to be granted in ALLRED
//   phase        000 ALLRED, 001 GREEN, 010 YELLOW, 011 OFF, 100 WALK
//   preempt_ack  preempted approach is being held green
//   ped_req      (PED_WALK_EN) pedestrian request pulse
//   walk         (PED_WALK_EN) walk indication
//
// state  | meaning
// ALLRED | clearance, all heads red; active_dir is the next approach
// GREEN  | active_dir green, may be held or truncated by preemption
// YELLOW | active_dir yellow
// OFF    | heads blanked while enable=0
// WALK   | pedestrian crossing, all heads red (PED_WALK_EN only)
module traffic_light_ctrl #(
  parameter int NUM_DIR      = 4,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int CNT_W        = 8
`ifdef PED_WALK_EN
  , parameter int WALK_TICKS = 4
`endif
  , localparam int DIR_W = $clog2(NUM_DIR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_en,
  input  logic                 enable,
  input  logic                 preempt_req,
  input  logic [DIR_W-1:0]     preempt_dir,
  output logic [2*NUM_DIR-1:0] light,
  output logic [DIR_W-1:0]     active_dir,
  output logic [2:0]           phase,
  output logic                 preempt_ack
`ifdef PED_WALK_EN
  , input  logic               ped_req,
  output logic                 walk
`endif
);

  typedef enum logic [2:0] {
    PH_ALLRED = 3'b000,
    PH_GREEN  = 3'b001,
    PH_YELLOW = 3'b010,
    PH_OFF    = 3'b011,
    PH_WALK   = 3'b100
  } phase_t;

  phase_t            phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIR_W-1:0]  dir_q, dir_d, next_dir;
  logic              ack_q, ack_d;
  logic              req_valid, cnt_last;
  logic [CNT_W-1:0]  dur_last;
`ifdef PED_WALK_EN
  logic              ped_q, ped_d;
`endif

  always_comb begin
    req_valid = preempt_req && (int'(preempt_dir) < NUM_DIR);
    if (req_valid)
      next_dir = preempt_dir;
    else if (dir_q == DIR_W'(NUM_DIR - 1))
      next_dir = '0;
    else
      next_dir = dir_q + DIR_W'(1);
  end

  always_comb begin
    case (phase_q)
      PH_GREEN:  dur_last = CNT_W'(GREEN_TICKS - 1);
      PH_YELLOW: dur_last = CNT_W'(YELLOW_TICKS - 1);
`ifdef PED_WALK_EN
      PH_WALK:   dur_last = CNT_W'(WALK_TICKS - 1);
`endif
      default:   dur_last = CNT_W'(ALLRED_TICKS - 1);
    endcase
    cnt_last = (cnt_q == dur_last);
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
`ifdef PED_WALK_EN
    ped_d   = ped_q | ped_req;
`endif
    if (!enable) begin
      phase_d = PH_OFF;
      cnt_d   = '0;
`ifdef PED_WALK_EN
      ped_d   = 1'b0;
`endif
    end else begin
      case (phase_q)
        PH_OFF: begin
          phase_d = PH_ALLRED;
          cnt_d   = '0;
          dir_d   = '0;
`ifdef PED_WALK_EN
          ped_d   = 1'b0;
`endif
        end
        PH_GREEN: begin
          if (req_valid && preempt_dir != dir_q) begin
            // Truncate green immediately, independent of the timebase.
            phase_d = PH_YELLOW;
            cnt_d   = '0;
          end else if (req_valid) begin
            // Hold: counter frozen while the request for this approach persists.
          end else if (tick_en) begin
            if (cnt_last) begin
              phase_d = PH_YELLOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        PH_YELLOW: begin
          if (tick_en) begin
            if (cnt_last) begin
              cnt_d = '0;
`ifdef PED_WALK_EN
              // Preemption wins over a pending walk; the latch stays set.
              if (!req_valid && ped_q) begin
                phase_d = PH_WALK;
                ped_d   = 1'b0;
              end else begin
                phase_d = PH_ALLRED;
                dir_d   = next_dir;
              end
`else
              phase_d = PH_ALLRED;
              dir_d   = next_dir;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef PED_WALK_EN
        PH_WALK: begin
          if (tick_en) begin
            if (cnt_last) begin
              phase_d = PH_ALLRED;
              cnt_d   = '0;
              dir_d   = next_dir;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
`endif
        PH_ALLRED: begin
          if (tick_en) begin
            if (cnt_last) begin
              phase_d = PH_GREEN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          phase_d = PH_ALLRED;
          cnt_d   = '0;
        end
      endcase
    end
    // Registered ack: high in every cycle that starts in a preemption hold.
    ack_d = enable && (phase_d == PH_GREEN) && req_valid && (preempt_dir == dir_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_ALLRED;
      cnt_q   <= '0;
      dir_q   <= '0;
      ack_q   <= 1'b0;
`ifdef PED_WALK_EN
      ped_q   <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ack_q   <= ack_d;
`ifdef PED_WALK_EN
      ped_q   <= ped_d;
`endif
    end
  end

  always_comb begin
    light = '0;
    case (phase_q)
      PH_GREEN:  light[2*int'(dir_q) +: 2] = 2'b10;
      PH_YELLOW: light[2*int'(dir_q) +: 2] = 2'b01;
      PH_OFF:    light = '1;
      default:   light = '0;
    endcase
  end

  assign active_dir  = dir_q;
  assign phase       = phase_q;
  assign preempt_ack = ack_q;
`ifdef PED_WALK_EN
  assign walk        = (phase_q == PH_WALK);
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a 4-approach instance exercises the
// sequence, gated timebase, preemption, blanking and async reset; a
// 3-approach instance sees an out-of-range preemption request.
module tb_traffic_light_ctrl;

  localparam logic [2:0] AR = 3'b000, GR = 3'b001, YE = 3'b010, OF = 3'b011, WK = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_en = 1'b1;
  logic       enable = 1'b1;
  logic       preempt_req = 1'b0;
  logic [1:0] preempt_dir = 2'd0;
  logic       preempt_req3 = 1'b0;
  logic [1:0] preempt_dir3 = 2'd0;

  logic [7:0] light;
  logic [1:0] active_dir;
  logic [2:0] phase;
  logic       preempt_ack;
  logic [5:0] light3;
  logic [1:0] active_dir3;
  logic [2:0] phase3;
  logic       preempt_ack3;
`ifdef PED_WALK_EN
  logic       ped_req = 1'b0;
  logic       ped_req3 = 1'b0;
  logic       walk, walk3;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl #(.NUM_DIR(4)) u_dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .enable(enable),
    .preempt_req(preempt_req), .preempt_dir(preempt_dir),
    .light(light), .active_dir(active_dir), .phase(phase), .preempt_ack(preempt_ack)
`ifdef PED_WALK_EN
    , .ped_req(ped_req), .walk(walk)
`endif
  );

  traffic_light_ctrl #(.NUM_DIR(3)) u_dut3 (
    .clk(clk), .reset(reset), .tick_en(tick_en), .enable(enable),
    .preempt_req(preempt_req3), .preempt_dir(preempt_dir3),
    .light(light3), .active_dir(active_dir3), .phase(phase3), .preempt_ack(preempt_ack3)
`ifdef PED_WALK_EN
    , .ped_req(ped_req3), .walk(walk3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic seg(input string tag, input logic [7:0] l, input logic [2:0] p,
                     input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_light"}, light, l);
      check({tag, "_phase"}, phase, p);
      check({tag, "_dir"}, active_dir, d);
      step(1);
    end
  endtask

  task automatic seg13(input string tag, input logic [7:0] l, input logic [5:0] l3,
                       input logic [2:0] p, input logic [1:0] d, input logic [1:0] d3,
                       input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_light"}, light, l);
      check({tag, "_phase"}, phase, p);
      check({tag, "_dir"}, active_dir, d);
      check({tag, "_light3"}, light3, l3);
      check({tag, "_phase3"}, phase3, p);
      check({tag, "_dir3"}, active_dir3, d3);
      check({tag, "_ack3"}, preempt_ack3, 1'b0);
      step(1);
    end
  endtask

  initial begin
    logic [7:0] gl, yl;
    logic [5:0] gl3, yl3;
    logic [1:0] d3;
    int n_ar, n_g, n_y;

    // Scenario 1 + 4: basic round-robin; 3-approach instance ignores dir 3.
    preempt_req3 = 1'b1;
    preempt_dir3 = 2'd3;
    do_reset();
    check("rst_light", light, 8'h00);
    check("rst_phase", phase, AR);
    check("rst_dir", active_dir, 2'd0);
    check("rst_ack", preempt_ack, 1'b0);
    for (int d = 0; d < 4; d++) begin
      d3  = 2'(d % 3);
      gl  = 8'h02 << (2 * d);
      yl  = 8'h01 << (2 * d);
      gl3 = 6'h02 << (2 * d3);
      yl3 = 6'h01 << (2 * d3);
      seg13("s1_ar", 8'h00, 6'h00, AR, 2'(d), d3, 1);
      seg13("s1_g", gl, gl3, GR, 2'(d), d3, 5);
      seg13("s1_y", yl, yl3, YE, 2'(d), d3, 2);
    end
    seg13("s1_wrap_ar", 8'h00, 6'h00, AR, 2'd0, 2'd1, 1);
    check("s1_wrap_g", light, 8'h02);
    check("s4_wrap_g3", light3, 6'h08);
    preempt_req3 = 1'b0;

    // Scenario 2: tick_en every 4th cycle.
    do_reset();
    n_ar = 0; n_g = 0; n_y = 0;
    for (int k = 0; k < 32; k++) begin
      tick_en = (k % 4 == 3);
      if (light == 8'h00 && phase == AR) n_ar++;
      if (light == 8'h02) n_g++;
      if (light == 8'h01) n_y++;
      step(1);
    end
    tick_en = 1'b1;
    check("s2_ar_cycles", n_ar, 4);
    check("s2_g_cycles", n_g, 20);
    check("s2_y_cycles", n_y, 8);
    check("s2_next_phase", phase, AR);
    check("s2_next_dir", active_dir, 2'd1);

    // Scenario 3: preempt to dir 2 during dir 0 green, hold, release.
    do_reset();
    seg("s3_ar0", 8'h00, AR, 2'd0, 1);
    seg("s3_g0", 8'h02, GR, 2'd0, 1);
    preempt_req = 1'b1;
    preempt_dir = 2'd2;
    check("s3_g0_still", light, 8'h02);
    step(1);
    check("s3_trunc_ack", preempt_ack, 1'b0);
    seg("s3_y0", 8'h01, YE, 2'd0, 2);
    seg("s3_ar2", 8'h00, AR, 2'd2, 1);
    for (int i = 0; i < 8; i++) begin
      check("s3_hold_light", light, 8'h20);
      check("s3_hold_ack", preempt_ack, 1'b1);
      step(1);
    end
    preempt_req = 1'b0;
    seg("s3_g2", 8'h20, GR, 2'd2, 5);
    check("s3_ack_off", preempt_ack, 1'b0);
    seg("s3_y2", 8'h10, YE, 2'd2, 2);
    seg("s3_ar3", 8'h00, AR, 2'd3, 1);
    check("s3_g3", light, 8'h80);

    // Scenario 5: blank during dir 1 green, re-enable, async reset mid-yellow.
    do_reset();
    seg("s5_ar0", 8'h00, AR, 2'd0, 1);
    seg("s5_g0", 8'h02, GR, 2'd0, 5);
    seg("s5_y0", 8'h01, YE, 2'd0, 2);
    seg("s5_ar1", 8'h00, AR, 2'd1, 1);
    step(1);
    check("s5_g1", light, 8'h08);
    enable = 1'b0;
    step(1);
    check("s5_off_light", light, 8'hFF);
    check("s5_off_phase", phase, OF);
    step(1);
    check("s5_off_hold", light, 8'hFF);
    enable = 1'b1;
    step(1);
    check("s5_reen_phase", phase, AR);
    check("s5_reen_dir", active_dir, 2'd0);
    check("s5_reen_light", light, 8'h00);
    step(1);
    check("s5_reen_g", light, 8'h02);
    seg("s5_g0b", 8'h02, GR, 2'd0, 5);
    check("s5_pre_rst", phase, YE);
    #2;
    reset = 1'b1;
    #1;
    check("s5_async_light", light, 8'h00);
    check("s5_async_phase", phase, AR);
    step(1);
    reset = 1'b0;

`ifdef PED_WALK_EN
    // Scenario 6: pedestrian walk after dir 0 yellow.
    do_reset();
    seg("s6_ar0", 8'h00, AR, 2'd0, 1);
    ped_req = 1'b1;
    seg("s6_g0a", 8'h02, GR, 2'd0, 1);
    ped_req = 1'b0;
    seg("s6_g0b", 8'h02, GR, 2'd0, 4);
    seg("s6_y0", 8'h01, YE, 2'd0, 2);
    for (int i = 0; i < 4; i++) begin
      check("s6_walk", walk, 1'b1);
      seg("s6_wk", 8'h00, WK, 2'd0, 1);
    end
    check("s6_walk_off", walk, 1'b0);
    seg("s6_ar1", 8'h00, AR, 2'd1, 1);
    check("s6_g1", light, 8'h08);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised multi-approach traffic-light controller for the airport apron and landside road crossings. It sequences NUM_DIR approaches round-robin through GREEN, YELLOW and ALL-RED phases. Phase durations are counted in ticks of an external timebase enable. It adds an enable/blank mode and emergency-vehicle preemption, and drives per-approach 2-bit light codes to the signal-head drivers.

Parameters:
NUM_DIR, 4, number of approaches (>=2)
GREEN_TICKS, 5, GREEN duration in tick_en pulses (>=1)
YELLOW_TICKS, 2, YELLOW duration in ticks (>=1)
ALLRED_TICKS, 1, ALL-RED clearance duration in ticks (>=1)
CNT_W, 8, phase counter width; every *_TICKS value must fit in CNT_W bits
DIR_W (localparam), $clog2(NUM_DIR), width of the direction index

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
tick_en  in  1  timebase enable; phase counters advance only when tick_en=1
enable  in  1  1=run; 0=blank all heads
preempt_req  in  1  emergency preemption request (level)
preempt_dir  in  DIR_W  approach requested for preemption
light  out  2*NUM_DIR  approach i at bits [2i+1:2i]; 00 red, 01 yellow, 10 green, 11 off
active_dir  out  DIR_W  approach currently green/yellow, or next to be granted while in ALLRED
phase  out  3  000 ALLRED, 001 GREEN, 010 YELLOW, 011 OFF, 100 WALK
preempt_ack  out  1  preempted approach is being held green

Behaviour:
- Reset, asynchronous: phase=ALLRED, cnt=0, active_dir=0, light all 00, preempt_ack=0, all internal flags cleared. Reset asserted mid-phase takes effect immediately, without waiting for a clock edge.
- All outputs are registered or decoded directly from registered state; no combinational path from inputs to outputs.
- Timed phases:
  - cnt increments on tick_en.
  - When tick_en=1 and cnt==DUR-1: advance to the next phase and set cnt=0.
  - DUR is ALLRED_TICKS, GREEN_TICKS or YELLOW_TICKS according to the current phase.
- Phase sequence:
  - ALLRED -> GREEN: active_dir unchanged.
  - GREEN -> YELLOW: active_dir unchanged.
  - YELLOW -> ALLRED: active_dir <= next_dir.
- next_dir selection:
  - If a valid preempt_req is present: next_dir = preempt_dir.
  - Otherwise: next_dir = active_dir+1, wrapping from NUM_DIR-1 to 0.
- light decode:
  - GREEN: approach active_dir=10, all others 00.
  - YELLOW: approach active_dir=01, all others 00.
  - ALLRED and WALK: all approaches 00.
  - OFF: all approaches 11.
- Preemption: a request is valid only when preempt_req=1 and preempt_dir<NUM_DIR; invalid requests are ignored.
  - GREEN with preempt_dir!=active_dir: the next cycle enters YELLOW with cnt=0 (green is truncated), regardless of tick_en.
  - GREEN with preempt_dir==active_dir: cnt is frozen and GREEN is held while the request persists. preempt_ack=1 during the hold. When the request drops, counting resumes from the frozen cnt.
  - YELLOW/ALLRED: the phase completes normally, and preemption is applied via next_dir at the end of YELLOW.
  - If preempt_dir changes mid-sequence, the value sampled at the YELLOW->ALLRED transition is the one used.
- enable=0 (any phase): the next cycle enters OFF with cnt=0; preemption is ignored while OFF. When enable returns to 1, the next cycle enters ALLRED with active_dir=0.
- Simultaneous events, in priority order: reset > enable=0 > preemption truncation > timer expiry.

Optional Feature:
Macro PED_WALK_EN.
- Defined:
  - Adds ports ped_req (in, 1) and walk (out, 1), and parameter WALK_TICKS (default 4).
  - A ped_req pulse sets a sticky latch.
  - At the next YELLOW end, the controller enters WALK instead of ALLRED: all lights 00, walk=1, for WALK_TICKS ticks. It then proceeds to ALLRED with active_dir=next_dir, and the latch is cleared on entry to WALK.
  - A valid preemption present at YELLOW end overrides WALK; the latch stays set.
  - Reset and OFF clear the latch.
- Not defined: no walk/ped_req ports and no WALK phase; code 100 never appears on phase.

Test Plan:
Common configuration: NUM_DIR=4, GREEN=5, YELLOW=2, ALLRED=1, tick_en=1.
1. Basic sequence: release reset -> light=8'h00 for 1 cycle; then 8'h02 for 5 cycles; 8'h01 for 2 cycles; 8'h00 for 1 cycle; 8'h08 (dir1 green) for 5 cycles; after dir3, wraps to 8'h02.
2. Gated timebase: tick_en high every 4th cycle -> each phase lasts 4x its tick count in cycles (dir0 green = 20 cycles).
3. Preemption to another approach: preempt_req=1, preempt_dir=2 at 2nd GREEN cycle of dir0 -> next cycle 8'h01 for 2 cycles; then 8'h00; then 8'h20 with preempt_ack=1, held while requested. Drop request -> 5 more cycles of green, then dir3 green 8'h80.
4. Invalid preemption: preempt_dir=3 with NUM_DIR=3 -> ignored; sequence identical to scenario 1.
5. Disable and reset: enable=0 mid-green -> next cycle light=all 1s, phase=011. enable=1 -> ALLRED then dir0 green. Async reset mid-YELLOW -> light=0, phase=000 before the next clk edge.
6. Walk (PED_WALK_EN): ped_req pulse during dir0 green -> after YELLOW, phase=100, walk=1 for 4 cycles, lights all 00; then ALLRED, then dir1 green.
